// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t CPU_OWN = 2'd0;
    localparam arb_state_t DBG_ACC = 2'd1;
    localparam arb_state_t DBG_RSP = 2'd2;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// CPU, debug and memory-side signals of the shared data-memory port.
interface dmem_port_arbiter_if import dmem_port_arbiter_pkg::*; #(
    parameter int unsigned ADDR_W = XLEN,
    parameter int unsigned DATA_W = XLEN
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    // Requester/memory environment view.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the M stage (priority) and a debug requester,
// forcing a one-cycle debug slot after MAX_WAIT contended cycles.
module dmem_port_arbiter import dmem_port_arbiter_pkg::*; #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t       state;
    arb_state_t       state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             dbg_go;
    logic             dbg_sel;

    sat_counter #(
        .W   (CNT_W),
        .MAX (MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CPU_OWN;
        end else begin
            state <= state_d;
        end
    end

    // Next state, starvation bookkeeping and port ownership.
    always_comb begin
        state_d       = state;
        cnt_inc       = 1'b0;
        cnt_clr       = !bus.dbg_req;
        dbg_go        = 1'b0;
        dbg_sel       = 1'b0;
        bus.dbg_gnt   = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.mem_we    = bus.cpu_req & bus.cpu_we;
        case (state)
            CPU_OWN: begin
                cnt_inc = bus.dbg_req & bus.cpu_req;
                dbg_go  = bus.dbg_req & (!bus.cpu_req || (starve_cnt == CNT_W'(MAX_WAIT)));
                if (dbg_go) begin
                    cnt_clr = 1'b1;
                    state_d = DBG_ACC;
                end
            end
            DBG_ACC: begin
                dbg_sel       = 1'b1;
                bus.dbg_gnt   = bus.dbg_req;
                bus.cpu_stall = bus.cpu_req;
                bus.mem_we    = bus.dbg_req & bus.dbg_we;
                // A dropped request cancels the access outright.
                state_d       = bus.dbg_req ? DBG_RSP : CPU_OWN;
            end
            DBG_RSP: begin
                state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    assign bus.mem_addr  = dbg_sel ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_wdata = dbg_sel ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.cpu_rdata = bus.mem_rdata;

    // Debug response: acknowledge every completed access, capture read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus.dbg_rvalid <= (state == DBG_ACC) && bus.dbg_req;
            if ((state == DBG_ACC) && bus.dbg_req && !bus.dbg_we) begin
                bus.dbg_rdata <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a sync-write/comb-read memory model.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(XLEN), .DATA_W(XLEN)) bus ();

    dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h55;
        #3;
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got %0b want 0", bus.dbg_gnt); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got %0b want 0", bus.cpu_stall); end
        total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got %0b want 0", bus.dbg_rvalid); end
        total++; if (bus.dbg_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", bus.dbg_rdata); end
        total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL rst_mem_addr got %h want 10", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'h55) begin bad++; $display("FAIL rst_mem_wdata got %h want 55", bus.mem_wdata); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rst_mem_we got %0b want 1", bus.mem_we); end
        step();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_dbg_read();
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h8; bus.cpu_wdata = 32'h0000000F;
        #2;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rd_preload_we got %0b want 1", bus.mem_we); end
        step();
        idle();
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h8;
        #2;
        total++; if (mem[2] !== 32'h0000000F) begin bad++; $display("FAIL rd_preload_mem got %h want f", mem[2]); end
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt_n got %0b want 0", bus.dbg_gnt); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_n got %0b want 0", bus.cpu_stall); end
        step(); #2;
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt_n1 got %0b want 1", bus.dbg_gnt); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_n1 got %0b want 0", bus.cpu_stall); end
        total++; if (bus.mem_addr !== 32'h8) begin bad++; $display("FAIL rd_addr_n1 got %h want 8", bus.mem_addr); end
        total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_n1 got %0b want 0", bus.dbg_rvalid); end
        step();
        bus.dbg_req = 1'b0;
        #2;
        total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid_n2 got %0b want 1", bus.dbg_rvalid); end
        total++; if (bus.dbg_rdata !== 32'h0000000F) begin bad++; $display("FAIL rd_rdata_n2 got %h want f", bus.dbg_rdata); end
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt_n2 got %0b want 0", bus.dbg_gnt); end
        step(); #2;
        total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_n3 got %0b want 0", bus.dbg_rvalid); end
    endtask

    task automatic test_dbg_write();
        step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h4; bus.dbg_wdata = 32'hDEADBEEF;
        #2;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL wr_we_n got %0b want 0", bus.mem_we); end
        step(); #2;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wr_we_n1 got %0b want 1", bus.mem_we); end
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt_n1 got %0b want 1", bus.dbg_gnt); end
        step();
        idle();
        #2;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL wr_we_n2 got %0b want 0", bus.mem_we); end
        total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL wr_rvalid_n2 got %0b want 1", bus.dbg_rvalid); end
        total++; if (mem[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem1 got %h want deadbeef", mem[1]); end
    endtask

    task automatic test_contended();
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h8;
        #2;
        for (int k = 0; k <= 4; k++) begin
            total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL ct_gnt_n%0d got %0b want 0", k, bus.dbg_gnt); end
            total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL ct_stall_n%0d got %0b want 0", k, bus.cpu_stall); end
            step(); #2;
        end
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL ct_gnt_n5 got %0b want 1", bus.dbg_gnt); end
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL ct_stall_n5 got %0b want 1", bus.cpu_stall); end
        total++; if (bus.mem_addr !== 32'h8) begin bad++; $display("FAIL ct_addr_n5 got %h want 8", bus.mem_addr); end
        step();
        bus.dbg_req = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h24; bus.cpu_wdata = 32'h12345678;
        #2;
        total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL ct_rvalid_n6 got %0b want 1", bus.dbg_rvalid); end
        total++; if (bus.dbg_rdata !== 32'h0000000F) begin bad++; $display("FAIL ct_rdata_n6 got %h want f", bus.dbg_rdata); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL ct_stall_n6 got %0b want 0", bus.cpu_stall); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL ct_we_n6 got %0b want 1", bus.mem_we); end
        total++; if (bus.mem_addr !== 32'h24) begin bad++; $display("FAIL ct_addr_n6 got %h want 24", bus.mem_addr); end
        step();
        idle();
        #2;
        total++; if (mem[9] !== 32'h12345678) begin bad++; $display("FAIL ct_mem9 got %h want 12345678", mem[9]); end
    endtask

    task automatic test_same_cycle_store();
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h28; bus.cpu_wdata = 32'hA5A5A5A5;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h2C; bus.dbg_wdata = 32'h77;
        #2;
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL sc_gnt_n got %0b want 0", bus.dbg_gnt); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sc_we_n got %0b want 1", bus.mem_we); end
        total++; if (bus.mem_addr !== 32'h28) begin bad++; $display("FAIL sc_addr_n got %h want 28", bus.mem_addr); end
        total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL sc_cnt_n got %0d want 0", dut.starve_cnt); end
        step();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        #2;
        total++; if (dut.starve_cnt !== 3'd1) begin bad++; $display("FAIL sc_cnt_n1 got %0d want 1", dut.starve_cnt); end
        total++; if (mem[10] !== 32'hA5A5A5A5) begin bad++; $display("FAIL sc_mem10 got %h want a5a5a5a5", mem[10]); end
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL sc_gnt_n1 got %0b want 0", bus.dbg_gnt); end
        step(); #2;
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL sc_gnt_n2 got %0b want 1", bus.dbg_gnt); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sc_we_n2 got %0b want 1", bus.mem_we); end
        total++; if (bus.mem_addr !== 32'h2C) begin bad++; $display("FAIL sc_addr_n2 got %h want 2c", bus.mem_addr); end
        step();
        idle();
        #2;
        total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL sc_rvalid_n3 got %0b want 1", bus.dbg_rvalid); end
        total++; if (mem[11] !== 32'h77) begin bad++; $display("FAIL sc_mem11 got %h want 77", mem[11]); end
        step();
    endtask

    task automatic test_drop();
        step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h30; bus.dbg_wdata = 32'h99;
        #2;
        step();
        bus.dbg_req = 1'b0;
        #2;
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL dr_gnt got %0b want 0", bus.dbg_gnt); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL dr_we got %0b want 0", bus.mem_we); end
        step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h8;
        #2;
        total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dr_rvalid got %0b want 0", bus.dbg_rvalid); end
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL dr_gnt_own got %0b want 0", bus.dbg_gnt); end
        step(); #2;
        total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL dr_regrant got %0b want 1", bus.dbg_gnt); end
        step();
        idle();
        #2;
        total++; if (mem[12] !== 32'h0) begin bad++; $display("FAIL dr_mem12 got %h want 0", mem[12]); end
        total++; if (bus.dbg_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid_re got %0b want 1", bus.dbg_rvalid); end
        step();
    endtask

    task automatic test_reset_mid();
        step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h8;
        #2;
        step();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0;
        #2;
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL rm_stall_pre got %0b want 1", bus.cpu_stall); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rm_stall got %0b want 0", bus.cpu_stall); end
        total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rm_gnt got %0b want 0", bus.dbg_gnt); end
        total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid got %0b want 0", bus.dbg_rvalid); end
        total++; if (bus.dbg_rdata !== 32'h0) begin bad++; $display("FAIL rm_rdata got %h want 0", bus.dbg_rdata); end
        step();
        rst_n = 1'b1;
        idle();
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'd15;
        step();
        bus.cpu_addr = 32'h4; bus.cpu_wdata = 32'd9;
        #2;
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL prog_stall got %0b want 0", bus.cpu_stall); end
        step();
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
        #2;
        total++; if (bus.cpu_rdata !== 32'd15) begin bad++; $display("FAIL prog_x3 got %0d want 15", bus.cpu_rdata); end
        step();
        bus.cpu_addr = 32'h0;
        #2;
        total++; if (bus.cpu_rdata !== 32'd15) begin bad++; $display("FAIL prog_x7 got %0d want 15", bus.cpu_rdata); end
        step();
        bus.cpu_addr = 32'h4;
        #2;
        total++; if (bus.cpu_rdata !== 32'd9) begin bad++; $display("FAIL prog_x9 got %0d want 9", bus.cpu_rdata); end
        total++; if (mem[0] !== 32'd15) begin bad++; $display("FAIL prog_mem0 got %0d want 15", mem[0]); end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_dbg_read();
        test_dbg_write();
        test_contended();
        test_same_cycle_store();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
